mips_boot_loader: RTL

- Synthesizable boot sequencer for the multi-cycle MIPS core. It replaces bench-side memory and register-file pokes with hardware.
- Holds the CPU in reset, zero-fills unified instr/data memory and the register file, then streams a program image into memory at a chosen base address.
- Releases CPU reset and counts run cycles. Sits between the external program source and cpu_top's memory/register-file write ports.

---
 rtl/mips_boot_loader.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/mips_boot_loader.sv
// Boot sequencer for the multi-cycle MIPS core: holds the CPU in reset, clears memory and
// register file, streams a program image into memory, then releases the CPU and counts cycles.
module mips_boot_loader #(
  parameter int DATA_W        = 32,
  parameter int ADDR_W        = 10,
  parameter int MEM_WORDS     = 1024,
  parameter int RF_REGS       = 32,
  parameter int CLEAR_ON_BOOT = 1,
  parameter int CNT_W         = 32
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              START,
  input  logic [ADDR_W-1:0] LOAD_BASE,
  input  logic [ADDR_W:0]   LOAD_LEN,
  input  logic              S_VALID,
  input  logic [DATA_W-1:0] S_DATA,
  output logic              S_READY,
  output logic              MEM_WE,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [DATA_W-1:0] MEM_WDATA,
  output logic              RF_WE,
  output logic [4:0]        RF_ADDR,
  output logic [DATA_W-1:0] RF_WDATA,
  output logic              CPU_RSTn,
  output logic              BUSY,
  output logic              DONE,
  output logic              ERR,
  output logic [CNT_W-1:0]  CYCLE_CNT
);

  localparam int CW = (ADDR_W + 1 > 6) ? ADDR_W + 1 : 6;

  typedef enum logic [2:0] {IDLE, CLR_MEM, CLR_RF, LOAD, FLUSH, RUN} state_t;

  state_t            state, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W:0]   len_q, len_d, acc_q, acc_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [ADDR_W+1:0] end_addr;
  logic              range_err, xfer;

  logic              mem_we_d, rf_we_d, cpu_rstn_d, busy_d, done_d, err_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_d;
  logic [4:0]        rf_addr_d;
  logic [CNT_W-1:0]  cyc_d;

  assign end_addr  = {2'b00, LOAD_BASE} + {1'b0, LOAD_LEN};
  assign range_err = end_addr > (ADDR_W + 2)'(MEM_WORDS);
  assign S_READY   = (state == LOAD) && (acc_q < len_q);
  assign xfer      = S_VALID && S_READY;
  assign RF_WDATA  = '0;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) state <= IDLE;
    else       state <= state_d;
  end

  // CLR_RF spends one extra cycle after its last write so LOAD opens on the release-timing grid.
  always_comb begin
    state_d = state;
    unique case (state)
      IDLE, RUN: begin
        if (START) begin
          if (range_err)               state_d = IDLE;
          else if (CLEAR_ON_BOOT != 0) state_d = (MEM_WORDS == 1) ? CLR_RF : CLR_MEM;
          else                         state_d = (LOAD_LEN == '0) ? FLUSH : LOAD;
        end
      end
      CLR_MEM: if (cnt_q == CW'(MEM_WORDS - 1)) state_d = CLR_RF;
      CLR_RF:  if (cnt_q == CW'(RF_REGS)) state_d = (len_q == '0) ? FLUSH : LOAD;
      LOAD:    if (xfer && (acc_q == len_q - (ADDR_W + 1)'(1))) state_d = FLUSH;
      FLUSH:   state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_we_d    = 1'b0;
    rf_we_d     = 1'b0;
    mem_addr_d  = MEM_ADDR;
    mem_wdata_d = MEM_WDATA;
    rf_addr_d   = RF_ADDR;
    cpu_rstn_d  = CPU_RSTn;
    busy_d      = BUSY;
    done_d      = DONE;
    err_d       = ERR;
    cyc_d       = CYCLE_CNT;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    base_d      = base_q;
    len_d       = len_q;
    unique case (state)
      IDLE, RUN: begin
        if (START) begin
          cpu_rstn_d = 1'b0;
          done_d     = 1'b0;
          if (range_err) begin
            err_d = 1'b1;
          end else begin
            err_d  = 1'b0;
            busy_d = 1'b1;
            cyc_d  = '0;
            base_d = LOAD_BASE;
            len_d  = LOAD_LEN;
            acc_d  = '0;
            // The first clear write lands on the START edge itself.
            if (CLEAR_ON_BOOT != 0) begin
              mem_we_d    = 1'b1;
              mem_addr_d  = '0;
              mem_wdata_d = '0;
              cnt_d       = (MEM_WORDS == 1) ? '0 : CW'(1);
            end
          end
        end else if (state == RUN && CYCLE_CNT != '1) begin
          cyc_d = CYCLE_CNT + CNT_W'(1);
        end
      end
      CLR_MEM: begin
        mem_we_d    = 1'b1;
        mem_addr_d  = cnt_q[ADDR_W-1:0];
        mem_wdata_d = '0;
        cnt_d       = (cnt_q == CW'(MEM_WORDS - 1)) ? '0 : cnt_q + CW'(1);
      end
      CLR_RF: begin
        if (cnt_q < CW'(RF_REGS)) begin
          rf_we_d   = 1'b1;
          rf_addr_d = cnt_q[4:0];
          cnt_d     = cnt_q + CW'(1);
        end
      end
      LOAD: begin
        if (xfer) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = base_q + acc_q[ADDR_W-1:0];
          mem_wdata_d = S_DATA;
          acc_d       = acc_q + (ADDR_W + 1)'(1);
        end
      end
      FLUSH: begin
        cpu_rstn_d = 1'b1;
        done_d     = 1'b1;
        busy_d     = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      MEM_WE    <= 1'b0;
      MEM_ADDR  <= '0;
      MEM_WDATA <= '0;
      RF_WE     <= 1'b0;
      RF_ADDR   <= '0;
      CPU_RSTn  <= 1'b0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      ERR       <= 1'b0;
      CYCLE_CNT <= '0;
      cnt_q     <= '0;
      acc_q     <= '0;
      base_q    <= '0;
      len_q     <= '0;
    end else begin
      MEM_WE    <= mem_we_d;
      MEM_ADDR  <= mem_addr_d;
      MEM_WDATA <= mem_wdata_d;
      RF_WE     <= rf_we_d;
      RF_ADDR   <= rf_addr_d;
      CPU_RSTn  <= cpu_rstn_d;
      BUSY      <= busy_d;
      DONE      <= done_d;
      ERR       <= err_d;
      CYCLE_CNT <= cyc_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      base_q    <= base_d;
      len_q     <= len_d;
    end
  end

endmodule
